ram_rd_arbiter: RTL and testbench

- Round-robin arbiter sharing the matrix RAM's single synchronous read port among NUM_REQ read clients (e.g. row fetch, column fetch, result readback, debug).
- Passes one write client straight through to the RAM write port.
- Resolves same-cycle read/write collisions to the same address as write-first: the reader gets the new data.
- Sits between the compute/sequencing logic and the ram instance; RAM read latency is 1 cycle (registered Q).

---
 rtl/mfa_pkg.sv | 41 ++++
 rtl/ram_rd_arbiter_rr_pick.sv | 30 +++
 rtl/ram_rd_arbiter.sv | 113 +++++++++++
 tb/tb_ram_rd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfa_pkg.sv
// Shared defaults and helpers for the matrix RAM front end.
// Provides address-slice math and a round-robin pick function.
package mfa_pkg;

  localparam int ADDR_LEN_DEF = 6;
  localparam int DATA_LEN_DEF = 8;
  localparam int MAX_REQ      = 8;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } pick_t;

  // Low bit of client i's address inside a packed address bus.
  function automatic int addr_lo(int i, int aw);
    return i * aw;
  endfunction

  // First set bit of valid[n-1:0], searching from ptr upward mod n.
  function automatic pick_t rr_pick(
    logic [MAX_REQ-1:0] valid,
    logic [2:0]         ptr,
    int                 n
  );
    pick_t r;
    int    j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!r.any && valid[j[2:0]]) begin
          r.any = 1'b1;
          r.idx = j[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_rd_arbiter_rr_pick.sv
// Combinational round-robin picker over N requesters, rotating base.
// Ports: valid_i/ptr_i in; one-hot gnt_o, index idx_o, any_o out.
module rr_pick_onehot
  import mfa_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [MAX_REQ-1:0] vld8;
  pick_t              p;

  always_comb begin
    vld8         = '0;
    vld8[N-1:0]  = valid_i;
    p            = rr_pick(vld8, 3'(ptr_i), N);
    any_o        = p.any;
    idx_o        = IW'(p.idx);
    gnt_o        = '0;
    if (p.any) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Round-robin arbiter for the matrix RAM read port, write pass-through.
// Ports: CLK/RST, req_* clients, wr_* client, ram_* RAM side, rsp_* out.
module ram_rd_arbiter
  import mfa_pkg::*;
#(
  parameter  int ADDR_LEN = ADDR_LEN_DEF,
  parameter  int DATA_LEN = DATA_LEN_DEF,
  parameter  int NUM_REQ  = 4,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int AW       = ADDR_LEN + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    wr_valid,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_LEN-1:0]     wr_data,
  output logic                    wr_ready,
  output logic [AW-1:0]           ram_rd_addr,
  output logic                    ram_wr_en,
  output logic [AW-1:0]           ram_wr_addr,
  output logic [DATA_LEN-1:0]     ram_wr_data,
  input  logic [DATA_LEN-1:0]     ram_q,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_LEN-1:0]     rsp_data
);

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                grant_any;
  logic [AW-1:0]       gnt_addr;
  logic                collide;

  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                bypass_q, bypass_d;
  logic [DATA_LEN-1:0] bypass_data_q, bypass_data_d;
  logic [AW-1:0]       last_addr_q, last_addr_d;

  rr_pick_onehot #(
    .N (NUM_REQ)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    grant_any = pick_any & ~RST;
    req_ready = RST ? '0 : pick_gnt;
    gnt_addr  = req_addr[addr_lo(int'(pick_idx), AW) +: AW];
    // Hold the last address when idle so the RAM input stays quiet.
    ram_rd_addr = grant_any ? gnt_addr : last_addr_q;
    // Same-cycle write to the address being read: RAM gives old data.
    collide   = grant_any & wr_valid & (wr_addr == gnt_addr);
  end

  always_comb begin
    wr_ready    = ~RST;
    ram_wr_en   = wr_valid & ~RST;
    ram_wr_addr = wr_addr;
    ram_wr_data = wr_data;
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    rsp_valid_d   = grant_any;
    rsp_id_d      = pick_idx;
    bypass_d      = collide;
    bypass_data_d = bypass_data_q;
    last_addr_d   = last_addr_q;
    if (grant_any) begin
      last_addr_d = gnt_addr;
      if (pick_idx == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                                 rr_ptr_d = pick_idx + ID_W'(1);
    end
    if (collide) bypass_data_d = wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      bypass_q      <= 1'b0;
      bypass_data_q <= '0;
      last_addr_q   <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      bypass_q      <= bypass_d;
      bypass_data_q <= bypass_data_d;
      last_addr_q   <= last_addr_d;
    end
  end

  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    if (!rsp_valid_q)  rsp_data = '0;
    else if (bypass_q) rsp_data = bypass_data_q;
    else               rsp_data = ram_q;
  end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter with a 1-cycle RAM model.
// Each task drives one scenario and checks against hand values.
module tb_ram_rd_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NR = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0] req_ready;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_q;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:127];

  always #5 CLK = ~CLK;

  ram_rd_arbiter #(
    .ADDR_LEN (6),
    .DATA_LEN (8),
    .NUM_REQ  (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_q       (ram_q),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data)
  );

  // Synchronous RAM: read returns pre-write contents on a collision.
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge CLK) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_q <= mem[ram_rd_addr];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input int c, input logic [AW-1:0] a);
    req_addr[c*AW +: AW] = a;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    req_valid = 4'hF;
    wr_valid  = 1'b1;
    wr_addr   = 7'd3;
    wr_data   = 8'h77;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 ||
          ram_wr_en !== 1'b0 || wr_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold k=%0d ready=%b rspv=%b wen=%b wrdy=%b",
                 k, req_ready, rsp_valid, ram_wr_en, wr_ready);
      end
      total++;
      if (rsp_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_data got=%h exp=00", rsp_data);
      end
    end
    wr_valid = 1'b0;
    RST      = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant ready=%b wrdy=%b exp 0001/1",
               req_ready, wr_ready);
    end
    tick();
    req_valid = 4'h0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_rsp v=%b id=%0d exp 1/0", rsp_valid, rsp_id);
    end
    tick();
  endtask

  // rr_ptr=1 on entry; leaves rr_ptr=1.
  task automatic test_single();
    do_write(7'd5, 8'h3C);
    req_valid = 4'b0100;
    set_addr(2, 7'd5);
    #1;
    total++;
    if (req_ready !== 4'b0100 || ram_rd_addr !== 7'd5) begin
      bad++;
      $display("FAIL single_grant ready=%b addr=%0d exp 0100/5",
               req_ready, ram_rd_addr);
    end
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h3C) begin
      bad++;
      $display("FAIL single_rsp v=%b id=%0d d=%h exp 1/2/3c",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL single_idle v=%b d=%h exp 0/00", rsp_valid, rsp_data);
    end
    // Idle read port holds the last granted address.
    total++;
    if (ram_rd_addr !== 7'd5) begin
      bad++;
      $display("FAIL idle_addr got=%0d exp=5", ram_rd_addr);
    end
    // Write offered during reset must not have landed at addr 3.
    req_valid = 4'b0001;
    set_addr(0, 7'd3);
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_write_dropped v=%b id=%0d d=%h exp 1/0/00",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  // rr_ptr=1 on entry; a lone grant to 3 moves it to 0.
  task automatic test_all();
    logic [NR-1:0] exp_g;
    req_valid = 4'b1000;
    tick();
    for (int c = 0; c < NR; c++) set_addr(c, 7'(20 + c));
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      total++;
      if (req_ready !== exp_g) begin
        bad++;
        $display("FAIL all_grant k=%0d got=%b exp=%b", k, req_ready, exp_g);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) begin
        bad++;
        $display("FAIL all_rsp k=%0d v=%b id=%0d exp 1/%0d",
                 k, rsp_valid, rsp_id, k % 4);
      end
    end
    req_valid = 4'h0;
    tick();
  endtask

  // rr_ptr=0 on entry; lone grant to 2 puts it at 3.
  task automatic test_rotation();
    logic [NR-1:0] exp_g [0:3];
    logic [1:0]    exp_i [0:3];
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0010;
    exp_g[2] = 4'b1000; exp_g[3] = 4'b0010;
    exp_i[0] = 2'd3; exp_i[1] = 2'd1;
    exp_i[2] = 2'd3; exp_i[3] = 2'd1;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (req_ready !== exp_g[k]) begin
        bad++;
        $display("FAIL rot_grant k=%0d got=%b exp=%b", k, req_ready, exp_g[k]);
      end
      tick();
      total++;
      if (rsp_id !== exp_i[k] || rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL rot_rsp k=%0d id=%0d exp=%0d", k, rsp_id, exp_i[k]);
      end
    end
    req_valid = 4'h0;
    tick();
  endtask

  // rr_ptr=2 on entry.
  task automatic test_collision();
    do_write(7'd9, 8'h11);
    wr_valid  = 1'b1;
    wr_addr   = 7'd9;
    wr_data   = 8'hA5;
    req_valid = 4'b0010;
    set_addr(1, 7'd9);
    #1;
    total++;
    if (req_ready !== 4'b0010 || ram_wr_en !== 1'b1 ||
        ram_wr_addr !== 7'd9 || ram_wr_data !== 8'hA5) begin
      bad++;
      $display("FAIL coll_setup ready=%b wen=%b wa=%0d wd=%h",
               req_ready, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    tick();
    wr_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hA5) begin
      bad++;
      $display("FAIL coll_bypass v=%b id=%0d d=%h exp 1/1/a5",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
      bad++;
      $display("FAIL coll_b2b v=%b d=%h exp 1/a5", rsp_valid, rsp_data);
    end
    tick();
  endtask

  // rr_ptr=2 on entry; reset must return it to 0.
  task automatic test_reset_flight();
    req_valid = 4'b0001;
    set_addr(0, 7'd5);
    RST = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL flight_ready got=%b exp=0000", req_ready);
    end
    tick();
    RST = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL flight_drop v=%b d=%h exp 0/00", rsp_valid, rsp_data);
    end
    req_valid = 4'b1110;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL flight_ptr ready=%b exp=0010", req_ready);
    end
    tick();
    req_valid = 4'h0;
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    tick();
    tick();
    test_reset();
    test_single();
    test_all();
    test_rotation();
    test_collision();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
